akp_line_sequencer: RTL and testbench
=====================================

AKP_LINE_SEQUENCER -- requirements
Module: akp_line_sequencer

Interface
REQ-001 Parameter CNT_W, default 12: width of the line-length and sample counters.
REQ-002 Parameter DV_LAT, default 3, range 1..8: clocks from read_fifo to data_valid, matching the GEN_FIFO + slc output pipeline.
REQ-003 Port clk, input, 1: single clock for all logic; the block uses one clock.
REQ-004 Port sbros, input, 1: reset, synchronous and active-high.
REQ-005 Port ink_i, input, 1: line-start strobe, one cycle wide.
REQ-006 Port ksi_en, input, 1: KSI coefficients ready, one-cycle pulse.
REQ-007 Port fifo_empty, input, 1: GEN_FIFO empty flag.
REQ-008 Port L_stroke, input, CNT_W: samples per line.
REQ-009 Port read_fifo, output, 1: GEN_FIFO / PELENG_DELAY read enable.
REQ-010 Port slc_data_en, output, 1: read_fifo delayed 1 clock, drives the slc data_en input.
REQ-011 Port data_valid, output, 1: output sample valid.
REQ-012 Port sop, output, 1: first sample of a line; coincident with its data_valid.
REQ-013 Port eop, output, 1: last sample of a line; coincident with its data_valid.
REQ-014 Port busy, output, 1: high in any state other than IDLE, or while the pipeline holds valid entries.
REQ-015 Port line_cnt, output, CNT_W: index of the last sample read.
REQ-016 Port underrun, output, 1: sticky flag, FIFO empty during READ.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_KSI, READ and DRAIN, held in registered state bits.
REQ-018 IDLE: ink_i=1 with L_stroke!=0 latches L_stroke into len_q and moves to WAIT_KSI. With L_stroke==0 the FSM stays in IDLE.
REQ-019 WAIT_KSI: ksi_en=1 clears the sample counter and moves to READ the next cycle.
REQ-020 READ: read_fifo SHALL be combinational: (state==READ) AND the read-permit term in REQ-031/032.
REQ-021 Each cycle with read_fifo=1 SHALL increment the counter; line_cnt follows the counter.
REQ-022 The read with counter==len_q-1 SHALL move the FSM to DRAIN. Exactly len_q reads are issued per line.
REQ-023 DRAIN: the FSM SHALL return to IDLE once the pipeline holds no valid entries.
REQ-024 A DV_LAT-deep shift pipeline SHALL carry {valid, first, last}:
- valid = read_fifo
- first = the read with counter 0
- last = the read with counter len_q-1
- data_valid, sop and eop are the pipeline outputs.
REQ-025 Latency:
- ksi_en at cycle t gives read_fifo high at t+1.
- The first data_valid and sop occur at t+1+DV_LAT.
REQ-026 ink_i in WAIT_KSI SHALL re-latch L_stroke and remain in WAIT_KSI.
REQ-027 ink_i in READ or DRAIN SHALL abort the line:
- read_fifo is low the next cycle.
- All pipeline valid bits clear.
- L_stroke is re-latched and the FSM moves to WAIT_KSI.
- No eop is emitted for the aborted line.
REQ-028 ksi_en in IDLE, READ or DRAIN SHALL be ignored.
REQ-029 If ink_i and ksi_en are both high in WAIT_KSI, ink_i SHALL take priority (re-latch, stay in WAIT_KSI).
REQ-030 With len_q==1, sop and eop SHALL assert in the same cycle.

Configuration
REQ-031 With AKP_SEQ_UNDERRUN_EN defined:
- The read permit is ~fifo_empty, so READ stalls while the FIFO is empty.
- underrun sets on any READ cycle with fifo_empty=1 and clears only on reset.
REQ-032 With AKP_SEQ_UNDERRUN_EN undefined:
- The read permit is constant 1.
- underrun is tied to 0.
- No stall logic is synthesized.

Reset
REQ-033 sbros=1 at a rising clk edge SHALL force:
- FSM to IDLE
- counter, len_q and pipeline to 0
- read_fifo, slc_data_en, data_valid, sop, eop, busy and underrun to 0
- line_cnt to 0
REQ-034 Reset SHALL override all other inputs in the same cycle, including mid-READ; no sop or eop is emitted after it.

Verification
REQ-035 Sequence: L_stroke=4, ink_i@0, ksi_en@3, fifo never empty, DV_LAT=3 -> read_fifo high on cycles 4-7; data_valid high 7-10; sop@7, eop@10; busy low from cycle 11.
REQ-036 Sequence: L_stroke=1, ink_i then ksi_en -> a single data_valid with sop=eop=1 in the same cycle.
REQ-037 Sequence: L_stroke=8, ink_i after 3 reads -> read_fifo low the next cycle, no eop, FSM in WAIT_KSI; a new ksi_en gives a full 8-sample line.
REQ-038 Sequence (macro defined): fifo_empty high for 2 cycles mid-line with L_stroke=5 -> read_fifo drops 2 cycles, still exactly 5 reads, underrun=1 until sbros.
REQ-039 Sequence: sbros pulsed during READ with L_stroke=6 -> all outputs 0 the next cycle; ksi_en without a new ink_i produces no reads.
REQ-040 Sequence: L_stroke=0 with ink_i, then ksi_en -> FSM stays in IDLE, no read_fifo, busy=0.

Source files
------------

// File: rtl/akp_line_sequencer.sv
// akp_line_sequencer
//   Sequences one line of samples out of GEN_FIFO: waits for the line-start
//   strobe and KSI coefficients, issues exactly len reads, and tracks each read
//   through a DV_LAT-deep pipeline so that data_valid/sop/eop line up with the
//   sample leaving the slc output stage.
//
// Parameters
//   CNT_W   width of the line-length and sample counters
//   DV_LAT  clocks from read_fifo to data_valid (1..8)
//
// Ports
//   clk          single clock
//   sbros        synchronous active-high reset
//   ink_i        line-start strobe (also aborts a line in progress)
//   ksi_en       KSI coefficients ready pulse
//   fifo_empty   GEN_FIFO empty flag
//   L_stroke     samples per line
//   read_fifo    GEN_FIFO / PELENG_DELAY read enable (combinational)
//   slc_data_en  read_fifo delayed one clock
//   data_valid   output sample valid
//   sop / eop    first / last sample of a line, coincident with data_valid
//   busy         FSM not idle, or pipeline still holds valid entries
//   line_cnt     sample counter
//   underrun     sticky: FIFO was empty during READ
//
// Build option
//   AKP_SEQ_UNDERRUN_EN  when defined, READ stalls on fifo_empty and the
//                        underrun flag is implemented; otherwise reads are
//                        unconditional and underrun is tied low.
module akp_line_sequencer #(
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned DV_LAT = 3
) (
  input  logic             clk,
  input  logic             sbros,
  input  logic             ink_i,
  input  logic             ksi_en,
  input  logic             fifo_empty,
  input  logic [CNT_W-1:0] L_stroke,
  output logic             read_fifo,
  output logic             slc_data_en,
  output logic             data_valid,
  output logic             sop,
  output logic             eop,
  output logic             busy,
  output logic [CNT_W-1:0] line_cnt,
  output logic             underrun
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_KSI = 2'd1,
    READ     = 2'd2,
    DRAIN    = 2'd3
  } state_e;

  // All pipeline stages except the output stage.
  localparam logic [DV_LAT-1:0] INNER_MASK = {DV_LAT{1'b1}} >> 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DV_LAT-1:0] pv_q, pv_d;
  logic [DV_LAT-1:0] pf_q, pf_d;
  logic [DV_LAT-1:0] pl_q, pl_d;
  logic              slc_q;
  logic              permit;
  logic              rd_first;
  logic              rd_last;
  logic              pipe_clr;
  logic              pipe_inner;

`ifdef AKP_SEQ_UNDERRUN_EN
  logic underrun_q;

  assign permit = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (sbros) begin
      underrun_q <= 1'b0;
    end else if (state_q == READ && fifo_empty) begin
      underrun_q <= 1'b1;
    end
  end

  assign underrun = underrun_q;
`else
  logic unused_fifo_empty;

  assign permit            = 1'b1;
  assign underrun          = 1'b0;
  assign unused_fifo_empty = fifo_empty;
`endif

  assign read_fifo  = (state_q == READ) && permit;
  assign rd_first   = read_fifo && (cnt_q == '0);
  assign rd_last    = read_fifo && (cnt_q == len_q - CNT_W'(1));
  // The output stage is consumed this cycle, so only inner stages keep DRAIN
  // alive; this lets busy fall the cycle after the last data_valid.
  assign pipe_inner = |(pv_q & INNER_MASK);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    pipe_clr = 1'b0;

    if (read_fifo) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (ink_i && (L_stroke != '0)) begin
          len_d   = L_stroke;
          state_d = WAIT_KSI;
        end
      end
      WAIT_KSI: begin
        if (ink_i) begin
          len_d = L_stroke;
        end else if (ksi_en && (len_q != '0)) begin
          // A zero length re-latched here is never started; it waits for a
          // fresh ink_i instead of wrapping the counter.
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (ink_i) begin
          len_d    = L_stroke;
          state_d  = WAIT_KSI;
          pipe_clr = 1'b1;
        end else if (rd_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ink_i) begin
          len_d    = L_stroke;
          state_d  = WAIT_KSI;
          pipe_clr = 1'b1;
        end else if (!pipe_inner) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pv_d = '0;
    pf_d = '0;
    pl_d = '0;
    if (!pipe_clr) begin
      pv_d = (pv_q << 1) | DV_LAT'(read_fifo);
      pf_d = (pf_q << 1) | DV_LAT'(rd_first);
      pl_d = (pl_q << 1) | DV_LAT'(rd_last);
    end
  end

  always_ff @(posedge clk) begin
    if (sbros) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      pv_q    <= '0;
      pf_q    <= '0;
      pl_q    <= '0;
      slc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      pv_q    <= pv_d;
      pf_q    <= pf_d;
      pl_q    <= pl_d;
      slc_q   <= read_fifo;
    end
  end

  assign slc_data_en = slc_q;
  assign data_valid  = pv_q[DV_LAT-1];
  assign sop         = pv_q[DV_LAT-1] & pf_q[DV_LAT-1];
  assign eop         = pv_q[DV_LAT-1] & pl_q[DV_LAT-1];
  assign busy        = (state_q != IDLE) || (|pv_q);
  assign line_cnt    = cnt_q;

endmodule

// File: tb/tb_akp_line_sequencer.sv
module tb_akp_line_sequencer;

  logic        clk = 1'b0;
  logic        sbros;
  logic        ink_i;
  logic        ksi_en;
  logic        fifo_empty;
  logic [11:0] L_stroke;
  logic        read_fifo;
  logic        slc_data_en;
  logic        data_valid;
  logic        sop;
  logic        eop;
  logic        busy;
  logic [11:0] line_cnt;
  logic        underrun;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  akp_line_sequencer #(.CNT_W(12), .DV_LAT(3)) dut (
    .clk        (clk),
    .sbros      (sbros),
    .ink_i      (ink_i),
    .ksi_en     (ksi_en),
    .fifo_empty (fifo_empty),
    .L_stroke   (L_stroke),
    .read_fifo  (read_fifo),
    .slc_data_en(slc_data_en),
    .data_valid (data_valid),
    .sop        (sop),
    .eop        (eop),
    .busy       (busy),
    .line_cnt   (line_cnt),
    .underrun   (underrun)
  );

  // exp bit order: read_fifo slc_data_en data_valid sop eop busy underrun
  typedef struct {
    logic        ink;
    logic        ksi;
    logic [11:0] len;
    logic [6:0]  exp;
    logic [11:0] lc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic ink, logic ksi, logic [11:0] len,
                              logic [6:0] e, logic [11:0] lc);
    vec_t r;
    r.ink = ink;
    r.ksi = ksi;
    r.len = len;
    r.exp = e;
    r.lc  = lc;
    return r;
  endfunction

  function automatic logic [6:0] outs();
    return {read_fifo, slc_data_en, data_valid, sop, eop, busy, underrun};
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 ns later,
  // well before the next rising edge.
  task automatic drive(input logic rst, input logic ink, input logic ksi,
                       input logic fe, input logic [11:0] len);
    @(negedge clk);
    sbros      = rst;
    ink_i      = ink;
    ksi_en     = ksi;
    fifo_empty = fe;
    L_stroke   = len;
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %b required %b", nm, act, exp);
    end
  endtask

  initial begin
    int   nreads;
    int   nsop;
    int   neop;
    logic exp_rf;
    logic exp_un;
    logic fe;

    sbros      = 1'b1;
    ink_i      = 1'b0;
    ksi_en     = 1'b0;
    fifo_empty = 1'b0;
    L_stroke   = '0;
    repeat (2) @(posedge clk);

    // reset must override a simultaneous ink_i/ksi_en
    drive(1'b1, 1'b1, 1'b1, 1'b0, 12'd5);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
    check("reset.outs", 32'(outs()), 32'(7'b0000000));
    check("reset.lc", 32'(line_cnt), 32'd0);

    // basic line, len 4, ink@0 ksi@3
    tv.push_back(mk(1, 0, 4, 7'b0000000, 0));
    tv.push_back(mk(0, 0, 4, 7'b0000010, 0));
    tv.push_back(mk(0, 0, 4, 7'b0000010, 0));
    tv.push_back(mk(0, 1, 4, 7'b0000010, 0));
    tv.push_back(mk(0, 0, 4, 7'b1000010, 0));
    tv.push_back(mk(0, 0, 4, 7'b1100010, 1));
    tv.push_back(mk(0, 0, 4, 7'b1100010, 2));
    tv.push_back(mk(0, 0, 4, 7'b1111010, 3));
    tv.push_back(mk(0, 0, 4, 7'b0110010, 4));
    tv.push_back(mk(0, 0, 4, 7'b0010010, 4));
    tv.push_back(mk(0, 0, 4, 7'b0010110, 4));
    tv.push_back(mk(0, 0, 4, 7'b0000000, 4));
    tv.push_back(mk(0, 0, 4, 7'b0000000, 4));
    // len 1: sop and eop together
    tv.push_back(mk(1, 0, 1, 7'b0000000, 4));
    tv.push_back(mk(0, 1, 1, 7'b0000010, 4));
    tv.push_back(mk(0, 0, 1, 7'b1000010, 0));
    tv.push_back(mk(0, 0, 1, 7'b0100010, 1));
    tv.push_back(mk(0, 0, 1, 7'b0000010, 1));
    tv.push_back(mk(0, 0, 1, 7'b0011110, 1));
    tv.push_back(mk(0, 0, 1, 7'b0000000, 1));
    // len 0: ink ignored, ksi ignored
    tv.push_back(mk(1, 0, 0, 7'b0000000, 1));
    tv.push_back(mk(0, 1, 0, 7'b0000000, 1));
    tv.push_back(mk(0, 0, 0, 7'b0000000, 1));
    // len 8, abort on the 3rd read, then a full line (ksi in READ ignored)
    tv.push_back(mk(1, 0, 8, 7'b0000000, 1));
    tv.push_back(mk(0, 1, 8, 7'b0000010, 1));
    tv.push_back(mk(0, 0, 8, 7'b1000010, 0));
    tv.push_back(mk(0, 0, 8, 7'b1100010, 1));
    tv.push_back(mk(1, 0, 8, 7'b1100010, 2));
    tv.push_back(mk(0, 0, 8, 7'b0100010, 3));
    tv.push_back(mk(0, 1, 8, 7'b0000010, 3));
    tv.push_back(mk(0, 0, 8, 7'b1000010, 0));
    tv.push_back(mk(0, 0, 8, 7'b1100010, 1));
    tv.push_back(mk(0, 1, 8, 7'b1100010, 2));
    tv.push_back(mk(0, 0, 8, 7'b1111010, 3));
    tv.push_back(mk(0, 0, 8, 7'b1110010, 4));
    tv.push_back(mk(0, 0, 8, 7'b1110010, 5));
    tv.push_back(mk(0, 0, 8, 7'b1110010, 6));
    tv.push_back(mk(0, 0, 8, 7'b1110010, 7));
    tv.push_back(mk(0, 0, 8, 7'b0110010, 8));
    tv.push_back(mk(0, 0, 8, 7'b0010010, 8));
    tv.push_back(mk(0, 0, 8, 7'b0010110, 8));
    tv.push_back(mk(0, 0, 8, 7'b0000000, 8));
    // re-latch in WAIT_KSI, ink beats ksi; final length 3
    tv.push_back(mk(1, 0, 2, 7'b0000000, 8));
    tv.push_back(mk(1, 1, 3, 7'b0000010, 8));
    tv.push_back(mk(0, 1, 9, 7'b0000010, 8));
    tv.push_back(mk(0, 0, 9, 7'b1000010, 0));
    tv.push_back(mk(0, 0, 9, 7'b1100010, 1));
    tv.push_back(mk(0, 0, 9, 7'b1100010, 2));
    tv.push_back(mk(0, 0, 9, 7'b0111010, 3));
    tv.push_back(mk(0, 0, 9, 7'b0010010, 3));
    tv.push_back(mk(0, 0, 9, 7'b0010110, 3));
    tv.push_back(mk(0, 0, 9, 7'b0000000, 3));

    foreach (tv[i]) begin
      drive(1'b0, tv[i].ink, tv[i].ksi, 1'b0, tv[i].len);
      check($sformatf("vec%0d.outs", i), 32'(outs()), 32'(tv[i].exp));
      check($sformatf("vec%0d.line_cnt", i), 32'(line_cnt), 32'(tv[i].lc));
    end

    // reset in the middle of READ, then a stray ksi_en
    drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd6);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 12'd6);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'd6);
    check("rst_mid.pre_rf", 32'(read_fifo), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'd6);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 12'd6);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'd6);
    check("rst_mid.outs", 32'(outs()), 32'(7'b0000000));
    check("rst_mid.lc", 32'(line_cnt), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 12'd6);
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 12'd6);
      check($sformatf("rst_mid.post%0d", k), 32'(outs()), 32'(7'b0000000));
    end

    // fifo_empty for two cycles mid-line, len 5
    drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd5);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 12'd5);
    nreads = 0;
    nsop   = 0;
    neop   = 0;
    for (int c = 0; c < 12; c++) begin
      fe = (c == 2 || c == 3);
      drive(1'b0, 1'b0, 1'b0, fe, 12'd5);
`ifdef AKP_SEQ_UNDERRUN_EN
      exp_rf = (c < 7) && !fe;
      exp_un = (c >= 3);
`else
      exp_rf = (c < 5);
      exp_un = 1'b0;
`endif
      check($sformatf("empty.c%0d", c), 32'({read_fifo, underrun}),
            32'({exp_rf, exp_un}));
      nreads += int'(read_fifo);
      nsop   += int'(sop);
      neop   += int'(eop);
    end
    check("empty.reads", 32'(nreads), 32'd5);
    check("empty.sop", 32'(nsop), 32'd1);
    check("empty.eop", 32'(neop), 32'd1);
    check("empty.busy", 32'(busy), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 12'd5);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'd5);
    check("empty.after_rst", 32'(outs()), 32'(7'b0000000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
